// File: rtl/pbl_pkg.sv
// rtl/pbl_pkg.sv - register map, field widths and APB phase encoding for apb_fir_regs
package pbl_pkg;

  localparam int APB_DW         = 32;
  localparam int CTRL_OFS       = 'h000;
  localparam int STATUS_OFS     = 'h004;
  localparam int ILE_WSP_OFS    = 'h008;
  localparam int ILE_PROBEK_OFS = 'h00C;
  localparam int ILE_RAZY_OFS   = 'h010;
  localparam int COEF_BASE      = 'h100;

  localparam int ILE_WSP_W    = 6;
  localparam int ILE_PROBEK_W = 14;
  localparam int ILE_RAZY_W   = 15;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;

  typedef enum logic [2:0] {
    SEL_CTRL, SEL_STATUS, SEL_WSP, SEL_PROBEK, SEL_RAZY, SEL_COEF, SEL_NONE
  } reg_sel_t;

  // A run may only be launched with a tap count the coefficient RAM can hold.
  function automatic logic cfg_valid(input logic [ILE_WSP_W-1:0]    wsp,
                                     input logic [ILE_PROBEK_W-1:0] probek,
                                     input logic [ILE_RAZY_W-1:0]   razy,
                                     input int                      n_wsp);
    return (wsp != '0) && (int'(wsp) <= n_wsp) && (probek != '0) && (razy != '0);
  endfunction

endpackage

// File: rtl/apb_fir_regs_if.sv
// rtl/apb_fir_regs_if.sv - APB bus bundle between the host bridge and apb_fir_regs
interface apb_fir_regs_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] p_paddr;
  logic              p_psel;
  logic              p_penable;
  logic              p_pwrite;
  logic [31:0]       p_pwdata;
  logic              p_pready;
  logic [31:0]       p_prdata;
  logic              p_pslverr;

  modport master (
    output p_paddr, p_psel, p_penable, p_pwrite, p_pwdata,
    input  p_pready, p_prdata, p_pslverr
  );

  modport slave (
    input  p_paddr, p_psel, p_penable, p_pwrite, p_pwdata,
    output p_pready, p_prdata, p_pslverr
  );
endinterface

// File: rtl/fir_coef_ram.sv
// rtl/fir_coef_ram.sv - FIR coefficient store, one write port and one registered read port
module fir_coef_ram #(
  parameter int N_WSP = 32,
  parameter int WSP_W = 16,
  parameter int AW    = $clog2(N_WSP)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WSP_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WSP_W-1:0] rdata
);

  logic [WSP_W-1:0] mem [N_WSP];

  // Array and read register are left unreset so the store maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/apb_fir_regs.sv
// rtl/apb_fir_regs.sv - APB register block holding FIR run config, coefficients, START and DONE/IRQ
module apb_fir_regs
  import pbl_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int N_WSP  = 32,
  parameter int WSP_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  apb_fir_regs_if.slave            apb,
  output logic [ILE_WSP_W-1:0]     f_ile_wsp,
  output logic [ILE_PROBEK_W-1:0]  f_ile_probek,
  output logic [ILE_RAZY_W-1:0]    f_ile_razy,
  output logic                     f_start,
  input  logic [$clog2(N_WSP)-1:0] f_adress_fir,
  input  logic                     f_fsm_mux_cdc,
  output logic [WSP_W-1:0]         f_wsp_data,
  input  logic                     f_pracuje,
  input  logic                     f_done,
  output logic                     irq
);

  localparam int AW = $clog2(N_WSP);

  // SETUP is the RAM fetch cycle of a coefficient read; ACCESS is the completing cycle.
  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_SETUP  = SETUP;
  localparam logic [1:0] ST_ACCESS = ACCESS;

  logic [1:0]       state;
  reg_sel_t         dec_sel, acc_sel;
  logic             dec_err;
  logic [31:0]      dec_rdata;
  logic [AW-1:0]    dec_idx, acc_idx;
  logic             coef_hit;
  logic             acc_wr;
  logic [15:0]      acc_data;
  logic             irq_en, done, done_clr;
  logic             ram_we;
  logic [AW-1:0]    ram_raddr;
  logic [WSP_W-1:0] ram_rdata;
  logic             fir_rd_q;
  logic [WSP_W-1:0] wsp_hold;
  logic             unused_wdata;

  assign unused_wdata = ^apb.p_pwdata[31:16];

  assign dec_idx  = apb.p_paddr[AW+1:2];
  assign coef_hit = (apb.p_paddr >= ADDR_W'(COEF_BASE)) &&
                    (apb.p_paddr <  ADDR_W'(COEF_BASE + 4 * N_WSP));

  always_comb begin
    dec_sel = SEL_NONE;
    if (apb.p_paddr[1:0] == 2'b00) begin
      if      (apb.p_paddr == ADDR_W'(CTRL_OFS))       dec_sel = SEL_CTRL;
      else if (apb.p_paddr == ADDR_W'(STATUS_OFS))     dec_sel = SEL_STATUS;
      else if (apb.p_paddr == ADDR_W'(ILE_WSP_OFS))    dec_sel = SEL_WSP;
      else if (apb.p_paddr == ADDR_W'(ILE_PROBEK_OFS)) dec_sel = SEL_PROBEK;
      else if (apb.p_paddr == ADDR_W'(ILE_RAZY_OFS))   dec_sel = SEL_RAZY;
      else if (coef_hit)                               dec_sel = SEL_COEF;
    end
  end

  // Config and coefficients are frozen while the FIR runs or owns the RAM port.
  always_comb begin
    dec_err = 1'b0;
    case (dec_sel)
      SEL_NONE:   dec_err = 1'b1;
      SEL_CTRL:   dec_err = apb.p_pwrite && apb.p_pwdata[0] &&
                            (f_pracuje || !cfg_valid(f_ile_wsp, f_ile_probek, f_ile_razy, N_WSP));
      SEL_WSP,
      SEL_PROBEK,
      SEL_RAZY:   dec_err = apb.p_pwrite && (f_pracuje || f_fsm_mux_cdc);
      SEL_COEF:   dec_err = f_fsm_mux_cdc || (apb.p_pwrite && f_pracuje);
      default:    dec_err = 1'b0;
    endcase
  end

  always_comb begin
    dec_rdata = '0;
    case (dec_sel)
      SEL_CTRL:   dec_rdata = {30'd0, irq_en, 1'b0};
      SEL_STATUS: dec_rdata = {30'd0, done, f_pracuje};
      SEL_WSP:    dec_rdata = 32'(f_ile_wsp);
      SEL_PROBEK: dec_rdata = 32'(f_ile_probek);
      SEL_RAZY:   dec_rdata = 32'(f_ile_razy);
      default:    dec_rdata = '0;
    endcase
  end

  assign ram_we    = (state == ST_ACCESS) && acc_wr && (acc_sel == SEL_COEF);
  assign done_clr  = (state == ST_ACCESS) && acc_wr && (acc_sel == SEL_STATUS) && acc_data[1];
  assign ram_raddr = f_fsm_mux_cdc ? f_adress_fir : dec_idx;

  fir_coef_ram #(
    .N_WSP (N_WSP),
    .WSP_W (WSP_W)
  ) u_coef_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (acc_idx),
    .wdata (acc_data[WSP_W-1:0]),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // The RAM output is shared with APB reads, so the FIR view holds its last fetched value.
  assign f_wsp_data = fir_rd_q ? ram_rdata : wsp_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      apb.p_pready  <= 1'b0;
      apb.p_prdata  <= '0;
      apb.p_pslverr <= 1'b0;
      acc_sel       <= SEL_NONE;
      acc_wr        <= 1'b0;
      acc_data      <= '0;
      acc_idx       <= '0;
      f_ile_wsp     <= '0;
      f_ile_probek  <= '0;
      f_ile_razy    <= '0;
      irq_en        <= 1'b0;
      done          <= 1'b0;
      irq           <= 1'b0;
      f_start       <= 1'b0;
      fir_rd_q      <= 1'b0;
      wsp_hold      <= '0;
    end else begin
      apb.p_pready  <= 1'b0;
      apb.p_prdata  <= '0;
      apb.p_pslverr <= 1'b0;
      f_start       <= 1'b0;
      fir_rd_q      <= f_fsm_mux_cdc;
      wsp_hold      <= f_wsp_data;
      done          <= f_done | (done & ~done_clr);
      irq           <= done & irq_en;

      case (state)
        ST_IDLE: begin
          if (apb.p_psel && !apb.p_penable) begin
            acc_sel  <= dec_sel;
            acc_wr   <= apb.p_pwrite && !dec_err;
            acc_data <= apb.p_pwdata[15:0];
            acc_idx  <= dec_idx;
            if (!dec_err && !apb.p_pwrite && (dec_sel == SEL_COEF)) begin
              state <= ST_SETUP;
            end else begin
              state         <= ST_ACCESS;
              apb.p_pready  <= 1'b1;
              apb.p_pslverr <= dec_err;
              apb.p_prdata  <= (dec_err || apb.p_pwrite) ? '0 : dec_rdata;
            end
          end
        end
        ST_SETUP: begin
          state        <= ST_ACCESS;
          apb.p_pready <= 1'b1;
          apb.p_prdata <= 32'(ram_rdata);
        end
        ST_ACCESS: begin
          // Writes commit only on the edge that closes the completing cycle.
          state <= ST_IDLE;
          if (acc_wr) begin
            case (acc_sel)
              SEL_CTRL: begin
                irq_en  <= acc_data[1];
                f_start <= acc_data[0];
              end
              SEL_WSP:    f_ile_wsp    <= acc_data[ILE_WSP_W-1:0];
              SEL_PROBEK: f_ile_probek <= acc_data[ILE_PROBEK_W-1:0];
              SEL_RAZY:   f_ile_razy   <= acc_data[ILE_RAZY_W-1:0];
              default: ;
            endcase
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_fir_regs.sv
// tb/tb_apb_fir_regs.sv - self-checking bench for apb_fir_regs against a register-map model
module tb_apb_fir_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  f_ile_wsp;
  logic [13:0] f_ile_probek;
  logic [14:0] f_ile_razy;
  logic        f_start;
  logic [4:0]  f_adress_fir;
  logic        mux_in;
  logic [15:0] f_wsp_data;
  logic        busy_in;
  logic        f_done;
  logic        irq;

  int total = 0;
  int bad   = 0;
  int m_starts = 0;
  int seen_starts = 0;

  logic [15:0] m_coef [32];
  int          m_wsp, m_probek, m_razy;
  bit          m_irq_en, m_done;

  always #5 clk = ~clk;

  apb_fir_regs_if #(.ADDR_W(12)) apb();

  apb_fir_regs dut (
    .clk           (clk),
    .rst           (rst),
    .apb           (apb),
    .f_ile_wsp     (f_ile_wsp),
    .f_ile_probek  (f_ile_probek),
    .f_ile_razy    (f_ile_razy),
    .f_start       (f_start),
    .f_adress_fir  (f_adress_fir),
    .f_fsm_mux_cdc (mux_in),
    .f_wsp_data    (f_wsp_data),
    .f_pracuje     (busy_in),
    .f_done        (f_done),
    .irq           (irq)
  );

  always @(posedge clk) if (f_start === 1'b1) seen_starts++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_coef(input int a);
    return (a >= 'h100) && (a < 'h180) && (a % 4 == 0);
  endfunction

  function automatic void m_reset();
    m_wsp = 0; m_probek = 0; m_razy = 0; m_irq_en = 0; m_done = 0;
  endfunction

  function automatic void m_read(input int a, output logic [31:0] d, output logic e);
    d = '0; e = 1'b0;
    if (a % 4 != 0)       e = 1'b1;
    else if (a == 'h000)  d = {30'd0, m_irq_en, 1'b0};
    else if (a == 'h004)  d = {30'd0, m_done, busy_in};
    else if (a == 'h008)  d = 32'(m_wsp);
    else if (a == 'h00C)  d = 32'(m_probek);
    else if (a == 'h010)  d = 32'(m_razy);
    else if (is_coef(a)) begin
      if (mux_in) e = 1'b1;
      else d = 32'(m_coef[(a - 'h100) / 4]);
    end else e = 1'b1;
  endfunction

  function automatic logic m_write(input int a, input logic [31:0] d, output logic st);
    st = 1'b0;
    if (a == 'h000) begin
      if (d[0] && (busy_in || m_wsp < 1 || m_wsp > 32 || m_probek == 0 || m_razy == 0)) return 1'b1;
      m_irq_en = d[1];
      st = d[0];
      return 1'b0;
    end
    if (a == 'h004) begin
      if (d[1]) m_done = 0;
      return 1'b0;
    end
    if (a == 'h008 || a == 'h00C || a == 'h010 || is_coef(a)) begin
      if (busy_in || mux_in) return 1'b1;
      if      (a == 'h008) m_wsp    = d % 64;
      else if (a == 'h00C) m_probek = d % 16384;
      else if (a == 'h010) m_razy   = d % 32768;
      else                 m_coef[(a - 'h100) / 4] = d[15:0];
      return 1'b0;
    end
    return 1'b1;
  endfunction

  // One APB transfer; optionally pulses f_done or asserts rst in the completing cycle.
  task automatic apb_xfer(input int a, input logic wr, input logic [31:0] wd,
                          input bit done_pulse, input bit rst_abort,
                          output logic [31:0] rd, output logic err, output int n,
                          output logic st_at_rdy);
    apb.p_paddr   = 12'(a);
    apb.p_pwrite  = wr;
    apb.p_pwdata  = wd;
    apb.p_psel    = 1'b1;
    apb.p_penable = 1'b0;
    @(posedge clk); #1;
    apb.p_penable = 1'b1;
    n = 1;
    while (apb.p_pready !== 1'b1 && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    rd = apb.p_prdata;
    err = apb.p_pslverr;
    st_at_rdy = f_start;
    if (done_pulse) f_done = 1'b1;
    if (rst_abort) rst = 1'b1;
    @(posedge clk); #1;
    apb.p_psel    = 1'b0;
    apb.p_penable = 1'b0;
    f_done        = 1'b0;
  endtask

  task automatic do_read(input int a, input string tag);
    logic [31:0] ed, rd;
    logic ee, er, st;
    int n;
    m_read(a, ed, ee);
    apb_xfer(a, 1'b0, 32'h0, 1'b0, 1'b0, rd, er, n, st);
    check({tag, " err"}, 32'(er), 32'(ee));
    check({tag, " data"}, rd, ed);
    check({tag, " cycles"}, 32'(n), (!ee && is_coef(a)) ? 32'd2 : 32'd1);
  endtask

  task automatic do_write_x(input int a, input logic [31:0] d, input bit dp, input string tag);
    logic [31:0] rd;
    logic ee, es, er, st;
    int n;
    ee = m_write(a, d, es);
    if (dp) m_done = 1;
    apb_xfer(a, 1'b1, d, dp, 1'b0, rd, er, n, st);
    check({tag, " err"}, 32'(er), 32'(ee));
    check({tag, " rdata"}, rd, 32'h0);
    check({tag, " cycles"}, 32'(n), 32'd1);
    check({tag, " start@ready"}, 32'(st), 32'd0);
    check({tag, " start"}, 32'(f_start), 32'(es));
    if (es) m_starts++;
  endtask

  task automatic do_write(input int a, input logic [31:0] d, input string tag);
    do_write_x(a, d, 1'b0, tag);
  endtask

  initial begin
    logic [31:0] rd;
    logic er, st;
    int n;

    rst = 1'b1;
    apb.p_paddr = '0; apb.p_psel = 1'b0; apb.p_penable = 1'b0;
    apb.p_pwrite = 1'b0; apb.p_pwdata = '0;
    f_adress_fir = '0; mux_in = 1'b0; busy_in = 1'b0; f_done = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst pready", 32'(apb.p_pready), 32'd0);
    check("rst prdata", apb.p_prdata, 32'd0);
    check("rst pslverr", 32'(apb.p_pslverr), 32'd0);
    check("rst f_start", 32'(f_start), 32'd0);
    check("rst f_wsp_data", 32'(f_wsp_data), 32'd0);
    check("rst irq", 32'(irq), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: register reset values and decode errors
    for (int a = 0; a <= 'h10; a += 4) do_read(a, "t1 reg");
    do_read('h020, "t1 unmapped");
    do_read('h002, "t1 unaligned");
    do_read('h180, "t1 past coef");

    // 2: coefficient fill and read-back
    for (int i = 0; i < 32; i++) do_write('h100 + 4 * i, 32'h1000 + 32'(i), "t2 coef wr");
    for (int i = 0; i < 32; i++) do_read('h100 + 4 * i, "t2 coef rd");
    for (int i = 0; i < 6; i++) begin
      int k;
      k = $urandom_range(0, 31);
      if (k == 5) k = 6;
      do_write('h100 + 4 * k, $urandom, "t2 coef rnd wr");
      do_read('h100 + 4 * k, "t2 coef rnd rd");
    end

    // 3: legal start and FIR-side coefficient port
    do_write('h008, 32'd8, "t3 wsp");
    do_write('h00C, 32'd100, "t3 probek");
    do_write('h010, 32'd1, "t3 razy");
    do_write('h000, 32'h3, "t3 start");
    @(posedge clk); #1;
    check("t3 start width", 32'(f_start), 32'd0);
    check("t3 f_ile_wsp", 32'(f_ile_wsp), 32'd8);
    check("t3 f_ile_probek", 32'(f_ile_probek), 32'd100);
    check("t3 f_ile_razy", 32'(f_ile_razy), 32'd1);
    do_read('h000, "t3 ctrl rd");
    mux_in = 1'b1; f_adress_fir = 5'd5;
    @(posedge clk); #1;
    check("t3 wsp_data[5]", 32'(f_wsp_data), 32'(m_coef[5]));
    for (int i = 0; i < 8; i++) begin
      int k;
      k = $urandom_range(0, 31);
      f_adress_fir = 5'(k);
      @(posedge clk); #1;
      check("t3 wsp_data rnd", 32'(f_wsp_data), 32'(m_coef[k]));
    end
    do_read('h104, "t3 coef rd while fir owns");
    do_write('h108, 32'h55, "t3 coef wr while fir owns");
    begin
      logic [15:0] held;
      held = m_coef[f_adress_fir];
      mux_in = 1'b0;
      f_adress_fir = f_adress_fir + 5'd1;
      repeat (2) @(posedge clk);
      #1;
      check("t3 wsp_data hold", 32'(f_wsp_data), 32'(held));
    end

    // 4: FIR busy blocks config, coefficients and START
    busy_in = 1'b1;
    do_write('h008, 32'd4, "t4 wsp busy");
    do_write('h10C, 32'd0, "t4 coef busy");
    do_write('h000, 32'h1, "t4 start busy");
    do_read('h004, "t4 status busy");
    do_read('h008, "t4 wsp kept");
    busy_in = 1'b0;
    do_read('h10C, "t4 coef kept");

    // 5: illegal tap counts refuse START
    do_write('h008, 32'd33, "t5 wsp33");
    do_write('h000, 32'h1, "t5 start wsp33");
    do_write('h008, 32'd0, "t5 wsp0");
    do_write('h000, 32'h1, "t5 start wsp0");
    do_write('h008, 32'd32, "t5 wsp32");
    do_write('h00C, 32'd0, "t5 probek0");
    do_write('h000, 32'h1, "t5 start probek0");
    do_write('h00C, 32'h7FFF, "t5 probek wide");
    do_write('h000, 32'h1, "t5 start wsp32");
    do_read('h00C, "t5 probek masked");

    // 6: DONE/IRQ behaviour
    do_write('h000, 32'h2, "t6 irq_en");
    f_done = 1'b1;
    @(posedge clk); #1;
    f_done = 1'b0;
    m_done = 1;
    check("t6 irq lag", 32'(irq), 32'd0);
    @(posedge clk); #1;
    check("t6 irq set", 32'(irq), 32'd1);
    do_read('h004, "t6 status done");
    do_write_x('h004, 32'h2, 1'b1, "t6 w1c vs done");
    do_read('h004, "t6 done kept");
    do_write('h004, 32'h2, "t6 w1c");
    do_read('h004, "t6 done cleared");
    check("t6 irq cleared", 32'(irq), 32'd0);

    // reset during the completing cycle of a coefficient write
    apb_xfer('h11C, 1'b1, 32'hBEEF, 1'b0, 1'b1, rd, er, n, st);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();
    check("t6 rst f_start", 32'(f_start), 32'd0);
    check("t6 rst f_ile_wsp", 32'(f_ile_wsp), 32'd0);
    do_read('h11C, "t6 coef after abort");
    do_read('h000, "t6 ctrl after abort");

    // randomized traffic against the model
    for (int it = 0; it < 80; it++) begin
      int sel, a;
      logic [31:0] d;
      busy_in = ($urandom_range(0, 3) == 0);
      mux_in  = ($urandom_range(0, 4) == 0);
      sel = $urandom_range(0, 11);
      case (sel)
        0, 1:    a = 'h000;
        2:       a = 'h004;
        3, 4:    a = 'h008;
        5:       a = 'h00C;
        6:       a = 'h010;
        7, 8:    a = 'h100 + 4 * $urandom_range(0, 31);
        9:       a = 'h100 + 4 * $urandom_range(0, 31) + $urandom_range(1, 3);
        10:      a = 4 * $urandom_range(5, 63);
        default: a = 'h180 + 4 * $urandom_range(0, 31);
      endcase
      d = $urandom;
      if (a == 'h008) d = $urandom_range(0, 40);
      if ($urandom_range(0, 1) == 1) do_write(a, d, "rnd wr");
      else do_read(a, "rnd rd");
    end
    busy_in = 1'b0;
    mux_in  = 1'b0;
    do_read('h008, "rnd final wsp");
    check("rnd f_ile_probek", 32'(f_ile_probek), 32'(m_probek));
    check("rnd f_ile_razy", 32'(f_ile_razy), 32'(m_razy));
    repeat (3) @(posedge clk);
    #1;
    check("start pulse count", 32'(seen_starts), 32'(m_starts));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
